// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder.
//   dmem_state_t : responder FSM states
//   dmem_op_t    : operation latched at grant
//   LAT_BITS     : width of the access-latency down-counter (LATENCY up to 15)
package dmem_pkg;

    localparam int unsigned LAT_BITS = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } dmem_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } dmem_op_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Per-lane data-memory bus between the LSUs (master) and the responder (slave).
//   read_valid/read_address      : per-lane read request
//   read_ready/read_data         : per-lane read completion and data
//   write_valid/address/data     : per-lane write request
//   write_ready                  : per-lane write completion
//   host_write_en/address/data   : host preload port
//   busy                         : responder not idle
interface dmem_responder_if #(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_LANES = 4
);

    logic [NUM_LANES-1:0] read_valid;
    logic [ADDR_BITS-1:0] read_address [NUM_LANES];
    logic [NUM_LANES-1:0] read_ready;
    logic [DATA_BITS-1:0] read_data [NUM_LANES];
    logic [NUM_LANES-1:0] write_valid;
    logic [ADDR_BITS-1:0] write_address [NUM_LANES];
    logic [DATA_BITS-1:0] write_data [NUM_LANES];
    logic [NUM_LANES-1:0] write_ready;
    logic                 host_write_en;
    logic [ADDR_BITS-1:0] host_write_address;
    logic [DATA_BITS-1:0] host_write_data;
    logic                 busy;

    modport master (
        output read_valid, read_address, write_valid, write_address, write_data,
        output host_write_en, host_write_address, host_write_data,
        input  read_ready, read_data, write_ready, busy
    );

    modport slave (
        input  read_valid, read_address, write_valid, write_address, write_data,
        input  host_write_en, host_write_address, host_write_data,
        output read_ready, read_data, write_ready, busy
    );

endinterface

// File: rtl/dmem_responder_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority lane this round
//   grant     : one-hot grant (all zero when no request)
//   grant_idx : index of the granted lane
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        grant,
    output logic [IDX_BITS-1:0] grant_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        // Scan N lanes starting at ptr, wrapping; first requester wins.
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr) + i) % N;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_BITS'(cand);
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: round-robin arbitration over NUM_LANES request lanes,
// one access at a time against an internal register array after LATENCY cycles.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : lane request/response bus, host preload port and busy flag
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 8,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned LATENCY   = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int unsigned LANE_BITS = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int unsigned DEPTH     = 2 ** ADDR_BITS;

    dmem_state_t          state_q, state_d;
    dmem_op_t             op_q, op_d;
    logic [LANE_BITS-1:0] lane_q, lane_d;
    logic [LANE_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic [LAT_BITS-1:0]  lat_q, lat_d;
    logic [NUM_LANES-1:0] read_ready_q, read_ready_d;
    logic [NUM_LANES-1:0] write_ready_q, write_ready_d;
    logic [DATA_BITS-1:0] read_data_q [NUM_LANES];
    logic [DATA_BITS-1:0] read_data_d [NUM_LANES];
    logic                 busy_q, busy_d;

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [NUM_LANES-1:0] req, grant;
    logic [LANE_BITS-1:0] grant_idx;
    logic                 commit;
    logic                 lane_valid;

    assign req = bus.read_valid | bus.write_valid;

    rr_arbiter #(
        .N(NUM_LANES)
    ) u_arb (
        .req      (req),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        lane_d        = lane_q;
        rr_ptr_d      = rr_ptr_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        lat_d         = lat_q;
        read_ready_d  = read_ready_q;
        write_ready_d = write_ready_q;
        read_data_d   = read_data_q;
        commit        = 1'b0;
        // Valid of the granted lane that matches the operation being served.
        lane_valid    = (op_q == OP_WRITE) ? bus.write_valid[lane_q] : bus.read_valid[lane_q];

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    lane_d = grant_idx;
                    // A lane asking for both gets its write first; the read re-arbitrates.
                    if (|(bus.write_valid & grant)) begin
                        op_d   = OP_WRITE;
                        addr_d = bus.write_address[grant_idx];
                    end else begin
                        op_d   = OP_READ;
                        addr_d = bus.read_address[grant_idx];
                    end
                    wdata_d = bus.write_data[grant_idx];
                    lat_d   = LAT_BITS'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (lat_q == '0) begin
                    commit = 1'b1;
                    if (op_q == OP_WRITE) begin
                        write_ready_d[lane_q] = 1'b1;
                    end else begin
                        read_data_d[lane_q]  = mem[addr_q];
                        read_ready_d[lane_q] = 1'b1;
                    end
                    state_d = RESPOND;
                end else begin
                    lat_d = lat_q - LAT_BITS'(1);
                end
            end
            RESPOND: begin
                if (!lane_valid) begin
                    read_ready_d  = '0;
                    write_ready_d = '0;
                    rr_ptr_d      = (lane_q == LANE_BITS'(NUM_LANES - 1)) ? '0
                                                                          : lane_q + 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            op_q          <= OP_READ;
            lane_q        <= '0;
            rr_ptr_q      <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            lat_q         <= '0;
            read_ready_q  <= '0;
            write_ready_q <= '0;
            read_data_q   <= '{default: '0};
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            lane_q        <= lane_d;
            rr_ptr_q      <= rr_ptr_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            lat_q         <= lat_d;
            read_ready_q  <= read_ready_d;
            write_ready_q <= write_ready_d;
            read_data_q   <= read_data_d;
            busy_q        <= busy_d;
        end
    end

    // Storage is not reset. Host write is issued last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (commit && (op_q == OP_WRITE)) begin
            mem[addr_q] <= wdata_q;
        end
        if (bus.host_write_en) begin
            mem[bus.host_write_address] <= bus.host_write_data;
        end
    end

    assign bus.read_ready  = read_ready_q;
    assign bus.write_ready = write_ready_q;
    assign bus.read_data   = read_data_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: u_dut (LATENCY=2) and u_dut1 (LATENCY=1).
module tb_dmem_responder;

    typedef struct {
        int         lane;
        bit         is_wr;
        logic [7:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb [$];

    dmem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_LANES(4)) bus ();
    dmem_responder_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_LANES(4)) bus1 ();

    dmem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_LANES(4), .LATENCY(2)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    dmem_responder #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_LANES(4), .LATENCY(1)
    ) u_dut1 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted, required completion");
        $fatal(1);
    end

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        bus.host_write_en      = 1'b1;
        bus.host_write_address = a;
        bus.host_write_data    = d;
        @(negedge clk);
        bus.host_write_en = 1'b0;
    endtask

    // Waits (bounded) for any ready on bus; lane = -1 on timeout.
    task automatic wait_ready(output int lane, output bit is_wr, output int cyc);
        lane  = -1;
        is_wr = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            cyc++;
            if ((bus.read_ready | bus.write_ready) != 4'b0) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus.read_ready[i] || bus.write_ready[i]) begin
                        lane  = i;
                        is_wr = bus.write_ready[i];
                    end
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus.read_ready, bus.write_ready, bus.busy, bus1.read_ready, bus1.write_ready,
             bus1.busy} !== 18'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got rr=%b wr=%b busy=%b rr1=%b wr1=%b busy1=%b, required 0",
                     bus.read_ready, bus.write_ready, bus.busy, bus1.read_ready,
                     bus1.write_ready, bus1.busy);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (bus.read_data[i] !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_rdata[%0d]: got %h, required 00", i, bus.read_data[i]);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_busy: got %b, required 0", bus.busy);
        end
    endtask

    task automatic test_single_read();
        int lane; bit is_wr; int cyc; exp_t e;
        host_wr(8'h10, 8'hA5);
        bus.read_address[0] = 8'h10;
        bus.read_valid[0]   = 1'b1;
        sb.push_back('{lane: 0, is_wr: 1'b0, data: 8'hA5});
        wait_ready(lane, is_wr, cyc);
        e = sb.pop_front();
        vectors++;
        if (lane !== e.lane || is_wr !== e.is_wr || cyc !== 3 ||
            bus.read_data[(lane < 0) ? 0 : lane] !== e.data) begin
            miscompares++;
            $display("FAIL single_read: got lane=%0d wr=%0d cyc=%0d data=%h, required lane=%0d wr=%0d cyc=3 data=%h",
                     lane, is_wr, cyc, bus.read_data[(lane < 0) ? 0 : lane], e.lane, e.is_wr,
                     e.data);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (bus.read_ready !== 4'b0001 || bus.read_data[0] !== 8'hA5 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL single_read_hold: got rr=%b data=%h busy=%b, required 0001 a5 1",
                         bus.read_ready, bus.read_data[0], bus.busy);
            end
        end
        bus.read_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.read_ready !== 4'b0 || bus.busy !== 1'b0 || bus.read_data[0] !== 8'hA5) begin
            miscompares++;
            $display("FAIL single_read_release: got rr=%b busy=%b data=%h, required 0000 0 a5",
                     bus.read_ready, bus.busy, bus.read_data[0]);
        end
    endtask

    task automatic test_write_then_read();
        int lane; bit is_wr; int cyc; exp_t e;
        bus.write_address[2] = 8'h22;
        bus.write_data[2]    = 8'h3C;
        bus.write_valid[2]   = 1'b1;
        sb.push_back('{lane: 2, is_wr: 1'b1, data: 8'h00});
        wait_ready(lane, is_wr, cyc);
        e = sb.pop_front();
        vectors++;
        if (lane !== e.lane || is_wr !== e.is_wr || cyc !== 3 || bus.read_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL wr_then_rd_write: got lane=%0d wr=%0d cyc=%0d rr=%b, required lane=2 wr=1 cyc=3 rr=0000",
                     lane, is_wr, cyc, bus.read_ready);
        end
        bus.write_valid[2] = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.write_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL wr_then_rd_release: got wr=%b, required 0000", bus.write_ready);
        end
        bus.read_address[2] = 8'h22;
        bus.read_valid[2]   = 1'b1;
        sb.push_back('{lane: 2, is_wr: 1'b0, data: 8'h3C});
        wait_ready(lane, is_wr, cyc);
        e = sb.pop_front();
        vectors++;
        if (lane !== e.lane || is_wr !== e.is_wr || cyc !== 3 ||
            bus.read_data[(lane < 0) ? 0 : lane] !== e.data) begin
            miscompares++;
            $display("FAIL wr_then_rd_read: got lane=%0d wr=%0d cyc=%0d data=%h, required lane=%0d wr=%0d cyc=3 data=%h",
                     lane, is_wr, cyc, bus.read_data[(lane < 0) ? 0 : lane], e.lane, e.is_wr,
                     e.data);
        end
        bus.read_valid[2] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_host_collision();
        int lane; bit is_wr; int cyc; exp_t e;
        bus.write_address[1] = 8'h05;
        bus.write_data[1]    = 8'h11;
        bus.write_valid[1]   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // The lane write commits on the next edge; host writes the same address there.
        bus.host_write_en      = 1'b1;
        bus.host_write_address = 8'h05;
        bus.host_write_data    = 8'h99;
        @(negedge clk);
        bus.host_write_en = 1'b0;
        vectors++;
        if (bus.write_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL collision_commit: got wr=%b, required 0010", bus.write_ready);
        end
        bus.write_valid[1] = 1'b0;
        @(negedge clk);
        bus.read_address[0] = 8'h05;
        bus.read_valid[0]   = 1'b1;
        sb.push_back('{lane: 0, is_wr: 1'b0, data: 8'h99});
        wait_ready(lane, is_wr, cyc);
        e = sb.pop_front();
        vectors++;
        if (lane !== e.lane || is_wr !== e.is_wr ||
            bus.read_data[(lane < 0) ? 0 : lane] !== e.data) begin
            miscompares++;
            $display("FAIL collision_read: got lane=%0d wr=%0d data=%h, required lane=%0d wr=%0d data=%h",
                     lane, is_wr, bus.read_data[(lane < 0) ? 0 : lane], e.lane, e.is_wr, e.data);
        end
        bus.read_valid[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_early_drop();
        int lane; bit is_wr; int cyc;
        bus.read_address[1] = 8'h10;
        bus.read_valid[1]   = 1'b1;
        @(negedge clk);
        bus.read_valid[1] = 1'b0;
        wait_ready(lane, is_wr, cyc);
        vectors++;
        if (lane !== 1 || is_wr !== 1'b0 || cyc !== 2 || bus.read_data[1] !== 8'hA5) begin
            miscompares++;
            $display("FAIL early_drop_ready: got lane=%0d wr=%0d cyc=%0d data=%h, required lane=1 wr=0 cyc=2 data=a5",
                     lane, is_wr, cyc, bus.read_data[1]);
        end
        @(negedge clk);
        vectors++;
        if (bus.read_ready !== 4'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL early_drop_pulse: got rr=%b busy=%b, required 0000 0",
                     bus.read_ready, bus.busy);
        end
    endtask

    task automatic test_reset_mid_access();
        int lane; bit is_wr; int cyc; exp_t e;
        host_wr(8'h40, 8'h00);
        bus.write_address[3] = 8'h40;
        bus.write_data[3]    = 8'h77;
        bus.write_valid[3]   = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_access_busy: got %b, required 1", bus.busy);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.read_ready !== 4'b0 || bus.write_ready !== 4'b0 ||
            bus.read_data[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL mid_access_reset: got busy=%b rr=%b wr=%b rd0=%h, required 0 0000 0000 00",
                     bus.busy, bus.read_ready, bus.write_ready, bus.read_data[0]);
        end
        @(negedge clk);
        bus.write_valid[3] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        bus.read_address[3] = 8'h40;
        bus.read_valid[3]   = 1'b1;
        sb.push_back('{lane: 3, is_wr: 1'b0, data: 8'h00});
        wait_ready(lane, is_wr, cyc);
        e = sb.pop_front();
        vectors++;
        if (lane !== e.lane || is_wr !== e.is_wr || cyc !== 3 ||
            bus.read_data[(lane < 0) ? 0 : lane] !== e.data) begin
            miscompares++;
            $display("FAIL mid_access_read: got lane=%0d wr=%0d cyc=%0d data=%h, required lane=%0d wr=%0d cyc=3 data=%h",
                     lane, is_wr, cyc, bus.read_data[(lane < 0) ? 0 : lane], e.lane, e.is_wr,
                     e.data);
        end
        bus.read_valid[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int lane; bit is_wr; int cyc; exp_t e;
        int served [4];
        for (int i = 0; i < 4; i++) begin
            logic [7:0] a;
            a = 8'h80 + 8'(i);
            host_wr(a, 8'hC0 + 8'(i));
            served[i] = 0;
        end
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                sb.push_back('{lane: i, is_wr: 1'b0, data: 8'hC0 + 8'(i)});
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus.read_address[i] = 8'h80 + 8'(i);
        end
        bus.read_valid = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            wait_ready(lane, is_wr, cyc);
            e = sb.pop_front();
            vectors++;
            if (lane !== e.lane || is_wr !== e.is_wr || cyc !== 3 ||
                bus.read_data[(lane < 0) ? 0 : lane] !== e.data) begin
                miscompares++;
                $display("FAIL contention[%0d]: got lane=%0d wr=%0d cyc=%0d data=%h, required lane=%0d wr=%0d cyc=3 data=%h",
                         n, lane, is_wr, cyc, bus.read_data[(lane < 0) ? 0 : lane], e.lane,
                         e.is_wr, e.data);
            end
            if (lane < 0) break;
            bus.read_valid[lane] = 1'b0;
            @(negedge clk);
            vectors++;
            if (bus.read_ready !== 4'b0) begin
                miscompares++;
                $display("FAIL contention_release[%0d]: got rr=%b, required 0000", n,
                         bus.read_ready);
            end
            served[lane]++;
            if (served[lane] < 2) bus.read_valid[lane] = 1'b1;
        end
        bus.read_valid = 4'b0;
        @(negedge clk);
    endtask

    task automatic test_rw_same_lane();
        bus1.write_address[0] = 8'h08;
        bus1.write_data[0]    = 8'h5A;
        bus1.read_address[0]  = 8'h08;
        bus1.write_valid[0]   = 1'b1;
        bus1.read_valid[0]    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus1.write_ready !== 4'b0001 || bus1.read_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL rw_same_lane_write: got wr=%b rr=%b, required 0001 0000",
                     bus1.write_ready, bus1.read_ready);
        end
        bus1.write_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus1.write_ready !== 4'b0 || bus1.read_ready !== 4'b0) begin
            miscompares++;
            $display("FAIL rw_same_lane_release: got wr=%b rr=%b, required 0000 0000",
                     bus1.write_ready, bus1.read_ready);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus1.read_ready !== 4'b0001 || bus1.read_data[0] !== 8'h5A) begin
            miscompares++;
            $display("FAIL rw_same_lane_read: got rr=%b data=%h, required 0001 5a",
                     bus1.read_ready, bus1.read_data[0]);
        end
        bus1.read_valid[0] = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus1.read_ready !== 4'b0 || bus1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rw_same_lane_done: got rr=%b busy=%b, required 0000 0",
                     bus1.read_ready, bus1.busy);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.read_valid          = '0;
        bus.write_valid         = '0;
        bus.host_write_en       = 1'b0;
        bus.host_write_address  = '0;
        bus.host_write_data     = '0;
        bus1.read_valid         = '0;
        bus1.write_valid        = '0;
        bus1.host_write_en      = 1'b0;
        bus1.host_write_address = '0;
        bus1.host_write_data    = '0;
        for (int i = 0; i < 4; i++) begin
            bus.read_address[i]   = '0;
            bus.write_address[i]  = '0;
            bus.write_data[i]     = '0;
            bus1.read_address[i]  = '0;
            bus1.write_address[i] = '0;
            bus1.write_data[i]    = '0;
        end

        test_reset();
        test_single_read();
        test_write_then_read();
        test_host_collision();
        test_early_drop();
        test_reset_mid_access();
        test_contention();
        test_rw_same_lane();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
